// File: rtl/basilisk_reg_scoreboard_if.sv
// basilisk_reg_scoreboard_if: decode/writeback side of the FP register scoreboard
interface basilisk_reg_scoreboard_if;
   logic            flush;
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      issue_rd;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [31:0][1:0] reg_status;
   logic            busy;
   logic            error;
   modport master (output flush, issue_valid, issue_rd, wb_valid, wb_rd,
                   input issue_ready, reg_status, busy, error);
   modport slave  (input flush, issue_valid, issue_rd, wb_valid, wb_rd,
                   output issue_ready, reg_status, busy, error);
endinterface

// File: rtl/basilisk_reg_scoreboard.sv
// basilisk_reg_scoreboard: per-register outstanding-write counters and status for the 32 FP registers
module basilisk_reg_scoreboard #(
   parameter int MAX_PENDING = 3
) (
   input logic                      clk,
   input logic                      rst,
   basilisk_reg_scoreboard_if.slave sb
);
   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_PENDING);
   localparam logic [1:0] ST_VALID = 2'b00, ST_INVALID = 2'b01, ST_UP = 2'b10, ST_DOWN = 2'b11;
   logic [CW-1:0]    r_cnt [32];
   logic [CW-1:0]    w_nxt [32];
   logic [31:0][1:0] r_status, w_status;
   logic [31:0]      w_iv, w_dv;
   logic             r_busy, r_err, w_busy, w_err, w_ready;
   // next counts and status; an unmatched writeback at zero holds 0 and flags error
   always_comb begin
      w_ready = r_cnt[sb.issue_rd] != MAXC;
      w_iv = (sb.issue_valid && w_ready && !sb.flush) ? 32'd1 << sb.issue_rd : '0;
      w_dv = (sb.wb_valid && !sb.flush) ? 32'd1 << sb.wb_rd : '0;
      w_err = 1'b0;
      w_busy = 1'b0;
      for (int r = 0; r < 32; r++) begin
         w_nxt[r] = r_cnt[r];
         if (sb.flush) w_nxt[r] = '0;
         else if (w_iv[r] && !w_dv[r]) w_nxt[r] = r_cnt[r] + 1'b1;
         else if (w_dv[r] && !w_iv[r]) begin
            if (r_cnt[r] == '0) w_err = 1'b1;
            else w_nxt[r] = r_cnt[r] - 1'b1;
         end
         w_status[r] = (w_nxt[r] == '0) ? ST_VALID :
                       (w_iv[r] && !w_dv[r]) ? ST_UP :
                       (w_dv[r] && !w_iv[r]) ? ST_DOWN : ST_INVALID;
         w_busy = w_busy | (w_nxt[r] != '0);
      end
   end
   // state registers; error is sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
         r_status <= '0;
         r_busy <= 1'b0;
         r_err <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) r_cnt[r] <= w_nxt[r];
         r_status <= w_status;
         r_busy <= w_busy;
         r_err <= r_err | w_err;
      end
   end
   assign sb.issue_ready = w_ready;
   assign sb.reg_status = r_status;
   assign sb.busy = r_busy;
   assign sb.error = r_err;
endmodule

// File: tb/tb_basilisk_reg_scoreboard.sv
// tb_basilisk_reg_scoreboard: directed vector table plus async reset sequence
module tb_basilisk_reg_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   basilisk_reg_scoreboard_if bus ();
   basilisk_reg_scoreboard #(.MAX_PENDING(3)) dut (.clk(clk), .rst(rst), .sb(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic       iv;
      logic [4:0] ird;
      logic       wv;
      logic [4:0] wrd;
      logic       fl;
      logic [4:0] cr;
      logic [1:0] st;
      logic       rdy;
      logic       bsy;
      logic       err;
   } vec_t;
   vec_t tv [22];
   function automatic vec_t mk(bit iv, int ird, bit wv, int wrd, bit fl, int cr, int st, bit rdy, bit bsy, bit err);
      vec_t v;
      v.iv = iv; v.ird = 5'(ird); v.wv = wv; v.wrd = 5'(wrd); v.fl = fl;
      v.cr = 5'(cr); v.st = 2'(st); v.rdy = rdy; v.bsy = bsy; v.err = err;
      return v;
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(bit iv, logic [4:0] ird, bit wv, logic [4:0] wrd, bit fl);
      bus.issue_valid = iv; bus.issue_rd = ird; bus.wb_valid = wv; bus.wb_rd = wrd; bus.flush = fl;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      drive(0, 0, 0, 0, 0);
      // expected status codes: 0 VALID, 1 INVALID, 2 SLIDEUP, 3 SLIDEDOWN
      tv[0]  = mk(1, 7, 0, 0, 0,  7, 2, 1, 1, 0);
      tv[1]  = mk(0, 7, 0, 0, 0,  7, 1, 1, 1, 0);
      tv[2]  = mk(0, 7, 0, 0, 0,  7, 1, 1, 1, 0);
      tv[3]  = mk(0, 7, 1, 7, 0,  7, 0, 1, 0, 0);
      tv[4]  = mk(1, 2, 0, 0, 0,  2, 2, 1, 1, 0);
      tv[5]  = mk(1, 2, 0, 0, 0,  2, 2, 1, 1, 0);
      tv[6]  = mk(1, 2, 0, 0, 0,  2, 2, 1, 1, 0);
      tv[7]  = mk(1, 2, 0, 0, 0,  2, 1, 0, 1, 0);
      tv[8]  = mk(0, 3, 0, 0, 0,  2, 1, 1, 1, 0);
      tv[9]  = mk(0, 2, 1, 2, 0,  2, 3, 0, 1, 0);
      tv[10] = mk(0, 2, 0, 0, 0,  2, 1, 1, 1, 0);
      tv[11] = mk(1, 9, 0, 0, 0,  9, 2, 1, 1, 0);
      tv[12] = mk(1, 9, 1, 9, 0,  9, 1, 1, 1, 0);
      tv[13] = mk(1, 9, 0, 0, 0,  9, 2, 1, 1, 0);
      tv[14] = mk(1, 9, 0, 0, 0,  9, 2, 1, 1, 0);
      tv[15] = mk(1, 9, 1, 9, 0,  2, 1, 0, 1, 0);
      tv[16] = mk(0, 4, 1, 4, 0,  4, 0, 1, 1, 1);
      tv[17] = mk(1, 1, 0, 0, 0,  1, 2, 1, 1, 1);
      tv[18] = mk(1, 1, 0, 0, 0,  1, 2, 1, 1, 1);
      tv[19] = mk(1, 31, 0, 0, 0, 31, 2, 1, 1, 1);
      tv[20] = mk(1, 6, 0, 0, 1,  6, 0, 1, 0, 1);
      tv[21] = mk(0, 6, 0, 0, 0,  1, 0, 1, 0, 1);
      repeat (2) @(negedge clk);
      chk("reset_status", 64'(bus.reg_status), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_error", 64'(bus.error), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 22; i++) begin
         drive(tv[i].iv, tv[i].ird, tv[i].wv, tv[i].wrd, tv[i].fl);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(bus.issue_ready), 64'(tv[i].rdy));
         @(negedge clk);
         chk($sformatf("v%0d_status", i), 64'(bus.reg_status[tv[i].cr]), 64'(tv[i].st));
         chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'(tv[i].bsy));
         chk($sformatf("v%0d_error", i), 64'(bus.error), 64'(tv[i].err));
      end
      // build cnt[5]=2, then reset asynchronously with traffic in flight
      repeat (2) begin
         drive(1, 5, 0, 0, 0);
         @(negedge clk);
      end
      chk("pre_rst_status5", 64'(bus.reg_status[5]), 64'd2);
      drive(1, 5, 1, 12, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_status", 64'(bus.reg_status), 64'd0);
      chk("async_rst_busy", 64'(bus.busy), 64'd0);
      chk("async_rst_error", 64'(bus.error), 64'd0);
      chk("async_rst_ready", 64'(bus.issue_ready), 64'd1);
      @(negedge clk);
      drive(0, 5, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_status", 64'(bus.reg_status), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_error", 64'(bus.error), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
